decode_stage: RTL and testbench

Registered RV32I instruction-decode stage sitting between instruction fetch and EX. Generalises the combinational decoder: parametrised PC width and register count (RV32I/RV32E), full immediate generation for all formats, illegal-instruction detection, and a one-entry ID/EX pipeline register with a valid/ready handshake, flush, and load-use interlock. Register-file read ports are driven combinationally from the incoming instruction. Read data is captured together with the decoded fields.

---
 rtl/decode_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with ID/EX register, flush and load-use interlock
module decode_stage #(
    parameter int PC_WIDTH = 10,
    parameter bit RV32E    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [31:0]         in_inst,
    input  logic                flush,
    output logic [4:0]          rf_rs1_addr,
    output logic [4:0]          rf_rs2_addr,
    input  logic [31:0]         rf_rs1_data,
    input  logic [31:0]         rf_rs2_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [6:0]          out_opcode,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [31:0]         out_imm,
    output logic [31:0]         out_rs1_data,
    output logic [31:0]         out_rs2_data,
    output logic [4:0]          out_rs1_addr,
    output logic [4:0]          out_rs2_addr,
    output logic [4:0]          out_rd_addr,
    output logic                out_rd_we,
    output logic                out_is_load,
    output logic                out_illegal
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_rd_used;
    logic        w_illegal;
    logic [31:0] w_imm_raw;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_sh;
    logic        w_hz;
    logic        w_accept;

    logic                r_valid;
    logic [PC_WIDTH-1:0] r_pc;
    logic [6:0]          r_opcode;
    logic [2:0]          r_funct3;
    logic [6:0]          r_funct7;
    logic [31:0]         r_imm;
    logic [31:0]         r_rs1_data;
    logic [31:0]         r_rs2_data;
    logic [4:0]          r_rs1_addr;
    logic [4:0]          r_rs2_addr;
    logic [4:0]          r_rd_addr;
    logic                r_rd_we;
    logic                r_is_load;
    logic                r_illegal;

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];
    assign w_funct7 = in_inst[31:25];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];
    assign w_rd     = in_inst[11:7];

    assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u  = {in_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign w_imm_sh = {27'b0, in_inst[24:20]};

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_rd_used  = 1'b0;
        w_imm_raw  = 32'b0;
        w_illegal  = (in_inst[1:0] != 2'b11);
        case (w_opcode)
            OP_REG: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_rd_used  = 1'b1;
                if (!((w_funct7 == 7'b0000000) ||
                      (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))))
                    w_illegal = 1'b1;
            end
            OP_IMM: begin
                w_rs1_used = 1'b1;
                w_rd_used  = 1'b1;
                w_imm_raw  = w_imm_i;
                if (w_funct3 == 3'b001) begin
                    w_imm_raw = w_imm_sh;
                    if (w_funct7 != 7'b0000000) w_illegal = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    w_imm_raw = w_imm_sh;
                    if (w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000) w_illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                w_rs1_used = 1'b1;
                w_rd_used  = 1'b1;
                w_imm_raw  = w_imm_i;
                if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) w_illegal = 1'b1;
            end
            OP_STORE: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm_raw  = w_imm_s;
                if (w_funct3 >= 3'b011) w_illegal = 1'b1;
            end
            OP_BRANCH: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm_raw  = w_imm_b;
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) w_illegal = 1'b1;
            end
            OP_JALR: begin
                w_rs1_used = 1'b1;
                w_rd_used  = 1'b1;
                w_imm_raw  = w_imm_i;
                if (w_funct3 != 3'b000) w_illegal = 1'b1;
            end
            OP_JAL: begin
                w_rd_used = 1'b1;
                w_imm_raw = w_imm_j;
            end
            OP_LUI, OP_AUIPC: begin
                w_rd_used = 1'b1;
                w_imm_raw = w_imm_u;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: w_illegal = 1'b1;
        endcase
        // Only fields the format actually uses are register numbers; others hold immediate bits.
        if (RV32E && ((w_rs1_used && w_rs1[4]) || (w_rs2_used && w_rs2[4]) || (w_rd_used && w_rd[4])))
            w_illegal = 1'b1;
    end

    assign rf_rs1_addr = w_rs1;
    assign rf_rs2_addr = w_rs2;

    assign w_hz = r_valid && r_is_load && (r_rd_addr != 5'd0) &&
                  ((w_rs1_used && w_rs1 == r_rd_addr) || (w_rs2_used && w_rs2 == r_rd_addr));

    assign in_ready = !flush && !w_hz && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (out_ready && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    // Data fields move only on accept so bubbles leave them stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_opcode   <= 7'b0;
            r_funct3   <= 3'b0;
            r_funct7   <= 7'b0;
            r_imm      <= 32'b0;
            r_rs1_data <= 32'b0;
            r_rs2_data <= 32'b0;
            r_rs1_addr <= 5'b0;
            r_rs2_addr <= 5'b0;
            r_rd_addr  <= 5'b0;
            r_rd_we    <= 1'b0;
            r_is_load  <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (!flush && w_accept) begin
            r_pc       <= in_pc;
            r_opcode   <= w_opcode;
            r_funct3   <= w_funct3;
            r_funct7   <= w_funct7;
            r_imm      <= w_illegal ? 32'b0 : w_imm_raw;
            r_rs1_data <= rf_rs1_data;
            r_rs2_data <= rf_rs2_data;
            r_rs1_addr <= (!w_illegal && w_rs1_used) ? w_rs1 : 5'b0;
            r_rs2_addr <= (!w_illegal && w_rs2_used) ? w_rs2 : 5'b0;
            r_rd_addr  <= (!w_illegal && w_rd_used) ? w_rd : 5'b0;
            r_rd_we    <= !w_illegal && w_rd_used;
            r_is_load  <= (w_opcode == OP_LOAD);
            r_illegal  <= w_illegal;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_opcode   = r_opcode;
    assign out_funct3   = r_funct3;
    assign out_funct7   = r_funct7;
    assign out_imm      = r_imm;
    assign out_rs1_data = r_rs1_data;
    assign out_rs2_data = r_rs2_data;
    assign out_rs1_addr = r_rs1_addr;
    assign out_rs2_addr = r_rs2_addr;
    assign out_rd_addr  = r_rd_addr;
    assign out_rd_we    = r_rd_we;
    assign out_is_load  = r_is_load;
    assign out_illegal  = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    localparam int PW = 10;

    logic          clk, rst, in_valid, flush, out_ready;
    logic [PW-1:0] in_pc;
    logic [31:0]   in_inst;

    logic          in_ready, out_valid, out_rd_we, out_is_load, out_illegal;
    logic [4:0]    rf_rs1_addr, rf_rs2_addr, out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [31:0]   rf_rs1_data, rf_rs2_data, out_imm, out_rs1_data, out_rs2_data;
    logic [PW-1:0] out_pc;
    logic [6:0]    out_opcode, out_funct7;
    logic [2:0]    out_funct3;

    logic          e_in_ready, e_out_valid, e_out_rd_we, e_out_is_load, e_out_illegal;
    logic [4:0]    e_rf_rs1_addr, e_rf_rs2_addr, e_out_rs1_addr, e_out_rs2_addr, e_out_rd_addr;
    logic [31:0]   e_rf_rs1_data, e_rf_rs2_data, e_out_imm, e_out_rs1_data, e_out_rs2_data;
    logic [PW-1:0] e_out_pc;
    logic [6:0]    e_out_opcode, e_out_funct7;
    logic [2:0]    e_out_funct3;

    int n_checks = 0;
    int n_errors = 0;

    // Register file stand-in: x0 reads 0, xN reads 0x1000+N.
    assign rf_rs1_data   = (rf_rs1_addr == 5'd0) ? 32'd0 : 32'h1000 + {27'd0, rf_rs1_addr};
    assign rf_rs2_data   = (rf_rs2_addr == 5'd0) ? 32'd0 : 32'h1000 + {27'd0, rf_rs2_addr};
    assign e_rf_rs1_data = (e_rf_rs1_addr == 5'd0) ? 32'd0 : 32'h1000 + {27'd0, e_rf_rs1_addr};
    assign e_rf_rs2_data = (e_rf_rs2_addr == 5'd0) ? 32'd0 : 32'h1000 + {27'd0, e_rf_rs2_addr};

    decode_stage #(.PC_WIDTH(PW), .RV32E(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .flush(flush), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_imm(out_imm), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
        .out_illegal(out_illegal)
    );

    decode_stage #(.PC_WIDTH(PW), .RV32E(1'b1)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .flush(flush), .rf_rs1_addr(e_rf_rs1_addr), .rf_rs2_addr(e_rf_rs2_addr),
        .rf_rs1_data(e_rf_rs1_data), .rf_rs2_data(e_rf_rs2_data), .out_valid(e_out_valid),
        .out_ready(out_ready), .out_pc(e_out_pc), .out_opcode(e_out_opcode), .out_funct3(e_out_funct3),
        .out_funct7(e_out_funct7), .out_imm(e_out_imm), .out_rs1_data(e_out_rs1_data),
        .out_rs2_data(e_out_rs2_data), .out_rs1_addr(e_out_rs1_addr), .out_rs2_addr(e_out_rs2_addr),
        .out_rd_addr(e_out_rd_addr), .out_rd_we(e_out_rd_we), .out_is_load(e_out_is_load),
        .out_illegal(e_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [PW-1:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_inst  = 32'd0;
    endtask

    logic [31:0] seq_inst [4] = '{32'hFE208EE3, 32'h7E20AFA3, 32'h001000EF, 32'h41F0D193};
    logic [31:0] seq_imm  [4] = '{32'hFFFFFFFC, 32'h000007FF, 32'h00000800, 32'h0000001F};

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_pc = '0;
        idle();
        tick(); tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_pc", {22'd0, out_pc}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // ADDI x1,x0,-1
        present(32'hFFF00093, 10'h010);
        #1 check("addi_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("addi_valid", {31'd0, out_valid}, 32'd1);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_rd", {27'd0, out_rd_addr}, 32'd1);
        check("addi_rd_we", {31'd0, out_rd_we}, 32'd1);
        check("addi_rs2", {27'd0, out_rs2_addr}, 32'd0);
        check("addi_pc", {22'd0, out_pc}, 32'h010);

        // Back-to-back immediates of each format
        for (int i = 0; i < 4; i++) begin
            present(seq_inst[i], 10'h020 + 10'(i * 4));
            tick();
            check("seq_valid", {31'd0, out_valid}, 32'd1);
            check("seq_imm", out_imm, seq_imm[i]);
            check("seq_pc", {22'd0, out_pc}, 32'h020 + 32'(i * 4));
        end

        // LW x5,0(x2) then dependent ADD x6,x5,x1
        present(32'h00012283, 10'h030);
        tick();
        check("lw_is_load", {31'd0, out_is_load}, 32'd1);
        check("lw_rs1_data", out_rs1_data, 32'h1002);
        present(32'h00128333, 10'h034);
        #1 check("hz_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("hz_bubble", {31'd0, out_valid}, 32'd0);
        check("hz_release", {31'd0, in_ready}, 32'd1);
        tick();
        check("hz_add_valid", {31'd0, out_valid}, 32'd1);
        check("hz_add_rd", {27'd0, out_rd_addr}, 32'd6);
        check("hz_add_rs1_data", out_rs1_data, 32'h1005);
        check("hz_add_rs2_data", out_rs2_data, 32'h1001);

        // Independent ADD x6,x0,x1 after a load: no bubble
        present(32'h00012283, 10'h038);
        tick();
        present(32'h00100333, 10'h03C);
        #1 check("nohz_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("nohz_valid", {31'd0, out_valid}, 32'd1);
        check("nohz_pc", {22'd0, out_pc}, 32'h03C);

        // Back-pressure
        present(32'hFFF00093, 10'h040);
        tick();
        out_ready = 1'b0;
        present(32'h7E20AFA3, 10'h044);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_pc", {22'd0, out_pc}, 32'h040);
            check("bp_imm", out_imm, 32'hFFFFFFFF);
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_pc", {22'd0, out_pc}, 32'h044);
        check("bp_next_imm", out_imm, 32'h7FF);
        idle();
        tick();
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // Flush while holding and presenting
        present(32'hFFF00093, 10'h050);
        tick();
        out_ready = 1'b0;
        present(32'h001000EF, 10'h054);
        flush = 1'b1;
        #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        idle();
        tick();
        check("flush_no_accept", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        present(32'h001000EF, 10'h054);
        tick();
        check("flush_re_valid", {31'd0, out_valid}, 32'd1);
        check("flush_re_pc", {22'd0, out_pc}, 32'h054);
        check("flush_re_imm", out_imm, 32'h800);

        // Illegal instructions
        present(32'h00000000, 10'h060);
        tick();
        check("ill_zero", {31'd0, out_illegal}, 32'd1);
        check("ill_zero_we", {31'd0, out_rd_we}, 32'd0);
        present(32'h403160B3, 10'h064);
        tick();
        check("ill_or", {31'd0, out_illegal}, 32'd1);
        check("ill_or_we", {31'd0, out_rd_we}, 32'd0);
        check("ill_or_rd", {27'd0, out_rd_addr}, 32'd0);
        present(32'h00000833, 10'h068);
        tick();
        check("e_ill", {31'd0, e_out_illegal}, 32'd1);
        check("e_ill_we", {31'd0, e_out_rd_we}, 32'd0);
        check("i_legal_x16", {31'd0, out_illegal}, 32'd0);
        check("i_rd_x16", {27'd0, out_rd_addr}, 32'd16);

        // Async reset mid-stall
        out_ready = 1'b0;
        present(32'hFFF00093, 10'h070);
        tick();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_imm", out_imm, 32'd0);
        idle();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
